// File: rtl/run_event_counter.sv
// Run statistics collector behind the serial run detector: counts run events, detect cycles
// and run lengths, with snapshot handshake and alarm. Define RUN_EVT_SAT_EN for saturating counters.
module run_event_counter #(
  parameter int CNT_W    = 8,
  parameter int LEN_W    = 8,
  parameter int ALARM_TH = 4
) (
  input  logic             clk,
  input  logic             nRESET,
  input  logic             det,
  input  logic             clr,
  input  logic             snap_req,
  output logic             snap_valid,
  output logic [CNT_W-1:0] snap_evt,
  output logic [CNT_W-1:0] snap_hit,
  output logic [LEN_W-1:0] snap_max,
  output logic             in_run,
  output logic             alarm,
  output logic             ovf
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

`ifdef RUN_EVT_SAT_EN
  function automatic logic [CNT_W-1:0] inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [LEN_W-1:0] inc_len(input logic [LEN_W-1:0] v);
    return (&v) ? v : v + LEN_W'(1);
  endfunction
`else
  function automatic logic [CNT_W-1:0] inc_cnt(input logic [CNT_W-1:0] v);
    return v + CNT_W'(1);
  endfunction

  function automatic logic [LEN_W-1:0] inc_len(input logic [LEN_W-1:0] v);
    return v + LEN_W'(1);
  endfunction
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] evt_q, evt_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [LEN_W-1:0] cur_q, cur_d;
  logic [LEN_W-1:0] max_q, max_d;
  logic [CNT_W-1:0] snap_evt_q, snap_evt_d;
  logic [CNT_W-1:0] snap_hit_q, snap_hit_d;
  logic [LEN_W-1:0] snap_max_q, snap_max_d;
  logic             snap_valid_q, snap_valid_d;
  logic [CNT_W-1:0] evt_base;
  logic [CNT_W-1:0] hit_base;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    snap_evt_d   = snap_evt_q;
    snap_hit_d   = snap_hit_q;
    snap_max_d   = snap_max_q;
    snap_valid_d = 1'b0;
    // A snapshot restarts the window, so this cycle counts on top of zero.
    evt_base     = snap_req ? '0 : evt_q;
    hit_base     = snap_req ? '0 : hit_q;
    evt_d        = evt_base;
    hit_d        = hit_base;

    if (det) begin
      hit_d = inc_cnt(hit_base);
      if (state_q == IDLE) begin
        state_d = RUN;
        evt_d   = inc_cnt(evt_base);
        cur_d   = LEN_W'(1);
      end else begin
        cur_d   = inc_len(cur_q);
      end
    end else begin
      state_d = IDLE;
      cur_d   = '0;
    end

    max_d = (snap_req || (cur_d > max_q)) ? cur_d : max_q;

    if (snap_req) begin
      snap_evt_d   = evt_q;
      snap_hit_d   = hit_q;
      snap_max_d   = max_q;
      snap_valid_d = 1'b1;
    end

    if (clr) begin
      state_d      = IDLE;
      evt_d        = '0;
      hit_d        = '0;
      cur_d        = '0;
      max_d        = '0;
      snap_evt_d   = '0;
      snap_hit_d   = '0;
      snap_max_d   = '0;
      snap_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q      <= IDLE;
      evt_q        <= '0;
      hit_q        <= '0;
      cur_q        <= '0;
      max_q        <= '0;
      snap_evt_q   <= '0;
      snap_hit_q   <= '0;
      snap_max_q   <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      evt_q        <= evt_d;
      hit_q        <= hit_d;
      cur_q        <= cur_d;
      max_q        <= max_d;
      snap_evt_q   <= snap_evt_d;
      snap_hit_q   <= snap_hit_d;
      snap_max_q   <= snap_max_d;
      snap_valid_q <= snap_valid_d;
    end
  end

`ifdef RUN_EVT_SAT_EN
  logic ovf_q, ovf_d;

  // Sticky: any increment that hits a counter already at all-ones.
  always_comb begin
    ovf_d = ovf_q | (det & ((&hit_base) |
                            ((state_q == IDLE) & (&evt_base)) |
                            ((state_q == RUN) & (&cur_q))));
    if (clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) ovf_q <= 1'b0;
    else         ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign snap_valid = snap_valid_q;
  assign snap_evt   = snap_evt_q;
  assign snap_hit   = snap_hit_q;
  assign snap_max   = snap_max_q;
  assign in_run     = (state_q == RUN);
  assign alarm      = (evt_q >= CNT_W'(ALARM_TH));

endmodule

// File: tb/tb_run_event_counter.sv
// Randomised and directed bench for run_event_counter against a count-based reference model.
// Honours RUN_EVT_SAT_EN the same way the design does.
module tb_run_event_counter;

  localparam int CNT_W    = 8;
  localparam int LEN_W    = 8;
  localparam int ALARM_TH = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
  localparam int LEN_MAX  = (1 << LEN_W) - 1;

  logic             clk      = 1'b0;
  logic             nRESET   = 1'b1;
  logic             det      = 1'b0;
  logic             clr      = 1'b0;
  logic             snap_req = 1'b0;
  logic             snap_valid;
  logic [CNT_W-1:0] snap_evt;
  logic [CNT_W-1:0] snap_hit;
  logic [LEN_W-1:0] snap_max;
  logic             in_run;
  logic             alarm;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  // Reference model: true (unbounded) counts since the window opened, folded to width on output.
  int m_run  = 0;
  int m_ev   = 0;
  int m_hit  = 0;
  int m_wmax = 0;
  int m_ovf  = 0;
  int m_sv   = 0;
  int m_sevt = 0;
  int m_shit = 0;
  int m_smax = 0;

  run_event_counter #(.CNT_W(CNT_W), .LEN_W(LEN_W), .ALARM_TH(ALARM_TH)) dut (
    .clk        (clk),
    .nRESET     (nRESET),
    .det        (det),
    .clr        (clr),
    .snap_req   (snap_req),
    .snap_valid (snap_valid),
    .snap_evt   (snap_evt),
    .snap_hit   (snap_hit),
    .snap_max   (snap_max),
    .in_run     (in_run),
    .alarm      (alarm),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  function automatic int fc(input int v);
`ifdef RUN_EVT_SAT_EN
    return (v > CNT_MAX) ? CNT_MAX : v;
`else
    return v % (CNT_MAX + 1);
`endif
  endfunction

  function automatic int fl(input int v);
`ifdef RUN_EVT_SAT_EN
    return (v > LEN_MAX) ? LEN_MAX : v;
`else
    return v % (LEN_MAX + 1);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    int cur;
    if (!nRESET) begin
      m_run = 0; m_ev = 0; m_hit = 0; m_wmax = 0; m_ovf = 0;
      m_sv = 0; m_sevt = 0; m_shit = 0; m_smax = 0;
    end else if (clr) begin
      m_run = 0; m_ev = 0; m_hit = 0; m_wmax = 0; m_ovf = 0;
      m_sv = 0; m_sevt = 0; m_shit = 0; m_smax = 0;
    end else begin
      m_sv = snap_req ? 1 : 0;
      if (snap_req) begin
        m_sevt = fc(m_ev);
        m_shit = fc(m_hit);
        m_smax = m_wmax;
        m_ev   = 0;
        m_hit  = 0;
      end
      if (det) begin
        if (m_run == 0) m_ev++;
        m_hit++;
        m_run++;
      end else begin
        m_run = 0;
      end
      cur = fl(m_run);
      if (snap_req || cur > m_wmax) m_wmax = cur;
`ifdef RUN_EVT_SAT_EN
      if (m_ev > CNT_MAX || m_hit > CNT_MAX || m_run > LEN_MAX) m_ovf = 1;
`endif
    end
  end

  always @(negedge clk) begin
    check("snap_valid", 32'(snap_valid), 32'(m_sv));
    check("snap_evt",   32'(snap_evt),   32'(m_sevt));
    check("snap_hit",   32'(snap_hit),   32'(m_shit));
    check("snap_max",   32'(snap_max),   32'(m_smax));
    check("in_run",     32'(in_run),     32'(m_run > 0));
    check("alarm",      32'(alarm),      32'(fc(m_ev) >= ALARM_TH));
    check("ovf",        32'(ovf),        32'(m_ovf));
  end

  // Inputs change 1ns after the falling edge, clear of both sampling edges.
  task automatic step(input logic d, input logic c, input logic s);
    #1;
    det      = d;
    clr      = c;
    snap_req = s;
    @(negedge clk);
  endtask

  initial begin
    logic d_prev;
    int   r;

    #1 nRESET = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_snap_valid", 32'(snap_valid), 32'd0);
    check("rst_in_run",     32'(in_run),     32'd0);
    check("rst_ovf",        32'(ovf),        32'd0);
    #1 nRESET = 1'b1;
    @(negedge clk);
    repeat (10) step(1'b0, 1'b0, 1'b0);
    check("idle_snap_evt", 32'(snap_evt), 32'd0);
    check("idle_alarm",    32'(alarm),    32'd0);
    check("idle_in_run",   32'(in_run),   32'd0);

    // Runs of 5 and 2 separated by a gap.
    repeat (5) step(1'b1, 1'b0, 1'b0);
    check("run_in_run", 32'(in_run), 32'd1);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("t2_snap_valid", 32'(snap_valid), 32'd1);
    check("t2_snap_evt",   32'(snap_evt),   32'd2);
    check("t2_snap_hit",   32'(snap_hit),   32'd7);
    check("t2_snap_max",   32'(snap_max),   32'd5);
    step(1'b0, 1'b0, 1'b0);
    check("t2_valid_drop", 32'(snap_valid), 32'd0);
    check("t2_hold_evt",   32'(snap_evt),   32'd2);

    // Snapshot in the middle of a run; the run is not recounted afterwards.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check("t3a_snap_evt", 32'(snap_evt), 32'd1);
    check("t3a_snap_hit", 32'(snap_hit), 32'd2);
    check("t3a_snap_max", 32'(snap_max), 32'd2);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("t3b_snap_evt", 32'(snap_evt), 32'd0);
    check("t3b_snap_hit", 32'(snap_hit), 32'd3);
    step(1'b0, 1'b0, 1'b0);

    // Four isolated pulses raise the alarm; a snapshot drops it.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0);
      check("t4_alarm", 32'(alarm), 32'(i == 3));
      step(1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b1);
    check("t4_alarm_drop", 32'(alarm),    32'd0);
    check("t4_snap_evt",   32'(snap_evt), 32'd4);

    // clr wins over a simultaneous snapshot.
    repeat (3) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b1, 1'b1);
    check("t5_snap_valid", 32'(snap_valid), 32'd0);
    check("t5_snap_evt",   32'(snap_evt),   32'd0);
    check("t5_snap_hit",   32'(snap_hit),   32'd0);

    // 300-cycle run exceeds the 8-bit widths.
    step(1'b0, 1'b1, 1'b0);
    repeat (300) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check("t6_snap_max", 32'(snap_max), 32'd255);
    check("t6_snap_evt", 32'(snap_evt), 32'd1);
`ifdef RUN_EVT_SAT_EN
    check("t6_snap_hit", 32'(snap_hit), 32'd255);
    check("t6_ovf",      32'(ovf),      32'd1);
`else
    check("t6_snap_hit", 32'(snap_hit), 32'd44);
    check("t6_ovf",      32'(ovf),      32'd0);
`endif
    step(1'b0, 1'b0, 1'b1);
`ifdef RUN_EVT_SAT_EN
    check("t6_snap_max2", 32'(snap_max), 32'd255);
    check("t6_ovf_sticky", 32'(ovf),     32'd1);
`else
    check("t6_snap_max2", 32'(snap_max), 32'd45);
`endif
    step(1'b0, 1'b1, 1'b0);
    check("t6_ovf_clr", 32'(ovf), 32'd0);

    // Random traffic with runs, snapshots, clears and occasional mid-run resets.
    d_prev = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 3) == 0) d_prev = ~d_prev;
      if (r == 99 && $urandom_range(0, 3) == 0) begin
        #1 nRESET = 1'b0;
        @(negedge clk);
        #1 nRESET = 1'b1;
        @(negedge clk);
      end else begin
        step(d_prev, r < 2, r < 15);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
